swervolf_axi2mem: RTL and testbench

//  AXI4 slave to single-port native memory bridge, directly downstream of the SoC core's 64-bit o_ram_* AXI port.

---
 rtl/swervolf_axi2mem.sv | 229 ++++++++++++++++++++++
 tb/tb_swervolf_axi2mem.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swervolf_axi2mem.sv
// Bridge from the core's 64-bit AXI4 RAM port to a single-port req/gnt word memory.
// Bursts are serialised one beat at a time with a single AXI transaction in flight.
module swervolf_axi2mem #(
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // Write address channel
    input  logic [ID_WIDTH-1:0]   i_awid,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [7:0]            i_awlen,
    input  logic [1:0]            i_awburst,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    // Write data channel
    input  logic [63:0]           i_wdata,
    input  logic [7:0]            i_wstrb,
    input  logic                  i_wlast,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    // Write response channel
    output logic [ID_WIDTH-1:0]   o_bid,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    // Read address channel
    input  logic [ID_WIDTH-1:0]   i_arid,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [7:0]            i_arlen,
    input  logic [1:0]            i_arburst,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    // Read data channel
    output logic [ID_WIDTH-1:0]   o_rid,
    output logic [63:0]           o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rlast,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    // Native memory port
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-4:0] o_mem_addr,
    output logic [63:0]           o_mem_wdata,
    output logic [7:0]            o_mem_be,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [63:0]           i_mem_rdata
);

    localparam int unsigned WordAw = ADDR_WIDTH - 3;

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrResp,
        StRdReq,
        StRdWait,
        StRdData
    } state_e;

    state_e              state_q, state_d;
    logic                wr_prio_q, wr_prio_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [WordAw-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [1:0]          burst_q, burst_d;
    logic                err_q, err_d;
    logic [63:0]         rdata_q, rdata_d;

    logic                beat_last;
    logic [WordAw-1:0]   addr_next;
    logic                unused_addr_lsb;

    // Byte offset within the 64-bit word carries no information for the memory.
    assign unused_addr_lsb = ^{i_awaddr[2:0], i_araddr[2:0]};

    assign beat_last = (cnt_q == len_q);
    // FIXED holds the address; INCR, WRAP and the reserved encoding all step one word.
    assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + WordAw'(1);

    assign o_bid      = id_q;
    assign o_rid      = id_q;
    assign o_bresp    = err_q ? 2'b10 : 2'b00;
    assign o_rresp    = 2'b00;
    assign o_rdata    = rdata_q;
    assign o_mem_addr = addr_q;

    always_comb begin
        state_d     = state_q;
        wr_prio_d   = wr_prio_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        err_d       = err_q;
        rdata_d     = rdata_q;

        o_awready   = 1'b0;
        o_arready   = 1'b0;
        o_wready    = 1'b0;
        o_bvalid    = 1'b0;
        o_rvalid    = 1'b0;
        o_rlast     = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_wdata = 64'd0;
        o_mem_be    = 8'd0;

        unique case (state_q)
            StIdle: begin
                o_awready = i_awvalid & (~i_arvalid | wr_prio_q);
                o_arready = i_arvalid & (~i_awvalid | ~wr_prio_q);
                // Priority only flips when both channels competed this cycle.
                if (i_awvalid && i_arvalid) begin
                    wr_prio_d = ~wr_prio_q;
                end
                if (o_awready) begin
                    id_d    = i_awid;
                    addr_d  = i_awaddr[ADDR_WIDTH-1:3];
                    len_d   = i_awlen;
                    burst_d = i_awburst;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = StWrData;
                end else if (o_arready) begin
                    id_d    = i_arid;
                    addr_d  = i_araddr[ADDR_WIDTH-1:3];
                    len_d   = i_arlen;
                    burst_d = i_arburst;
                    cnt_d   = 8'd0;
                    state_d = StRdReq;
                end
            end

            StWrData: begin
                o_mem_req   = i_wvalid;
                o_mem_we    = 1'b1;
                o_mem_be    = i_wstrb;
                o_mem_wdata = i_wdata;
                o_wready    = i_mem_gnt;
                if (i_wvalid && i_mem_gnt) begin
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 8'd1;
                    if (i_wlast != beat_last) begin
                        err_d = 1'b1;
                    end
                    // Whichever of wlast or the beat count comes first closes the burst.
                    if (i_wlast || beat_last) begin
                        state_d = StWrResp;
                    end
                end
            end

            StWrResp: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end

            StRdReq: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) begin
                    state_d = StRdWait;
                end
            end

            StRdWait: begin
                if (i_mem_rvalid) begin
                    rdata_d = i_mem_rdata;
                    state_d = StRdData;
                end
            end

            StRdData: begin
                o_rvalid = 1'b1;
                o_rlast  = beat_last;
                if (i_rready) begin
                    if (beat_last) begin
                        state_d = StIdle;
                    end else begin
                        addr_d  = addr_next;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StRdReq;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wr_prio_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            burst_q   <= 2'b00;
            err_q     <= 1'b0;
            rdata_q   <= 64'd0;
        end else begin
            state_q   <= state_d;
            wr_prio_q <= wr_prio_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

`ifndef SYNTHESIS
    a_one_accept: assert property (@(posedge clk) disable iff (!rst_n)
        !(o_awready && o_arready));
    a_req_states: assert property (@(posedge clk) disable iff (!rst_n)
        o_mem_req |-> (state_q == StWrData || state_q == StRdReq));
`endif

endmodule

// File: tb/tb_swervolf_axi2mem.sv
// Randomised bench for swervolf_axi2mem: AXI master, req/gnt memory responder and a
// transaction-level reference model of the expected memory operations and responses.
`timescale 1ns/1ps
module tb_swervolf_axi2mem;

    localparam int WA = 29;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  i_awid = '0, i_arid = '0, o_bid, o_rid;
    logic [31:0] i_awaddr = '0, i_araddr = '0;
    logic [7:0]  i_awlen = '0, i_arlen = '0, i_wstrb = '0, o_mem_be;
    logic [1:0]  i_awburst = '0, i_arburst = '0, o_bresp, o_rresp;
    logic        i_awvalid = 0, i_arvalid = 0, i_wvalid = 0, i_wlast = 0;
    logic        i_bready = 0, i_rready = 0, i_mem_gnt = 0, i_mem_rvalid = 0;
    logic        o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast;
    logic        o_mem_req, o_mem_we;
    logic [63:0] i_wdata = '0, o_rdata, o_mem_wdata, i_mem_rdata = '0;
    logic [WA-1:0] o_mem_addr;

    always #5 clk = ~clk;

    swervolf_axi2mem #(.ID_WIDTH(6), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awburst(i_awburst),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_gnt(i_mem_gnt),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          we;
        logic [WA-1:0] addr;
        logic [63:0]   data;
        logic [7:0]    be;
    } op_t;

    op_t         ops[$];                  // memory operations seen by the responder
    logic [63:0] mem [logic [WA-1:0]];    // responder storage
    logic [63:0] ref_mem [logic [WA-1:0]]; // reference model storage
    int          gnt_pct = 100;
    int          rd_lat = -1;
    bit          resp_hold = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [63:0] pend_data = '0;
    bit          rd_first;

    function automatic logic [63:0] dflt(input logic [WA-1:0] a);
        return {3'b101, a, ~a, 3'b011};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mem_rd(input logic [WA-1:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [WA-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memory responder: decides grants on the falling edge, returns reads in order.
    always @(negedge clk or negedge rst_n) begin
        op_t o;
        if (!rst_n) begin
            i_mem_gnt    = 0;
            i_mem_rvalid = 0;
            pend         = 0;
        end else begin
            i_mem_rvalid = 0;
            if (pend && !resp_hold) begin
                if (pend_cnt == 0) begin
                    i_mem_rvalid = 1;
                    i_mem_rdata  = pend_data;
                    pend         = 0;
                end else begin
                    pend_cnt--;
                end
            end
            i_mem_gnt = 0;
            if (o_mem_req && ($urandom_range(0, 99) < gnt_pct)) begin
                i_mem_gnt = 1;
                o.we   = o_mem_we;
                o.addr = o_mem_addr;
                o.data = o_mem_we ? o_mem_wdata : 64'd0;
                o.be   = o_mem_we ? o_mem_be : 8'd0;
                ops.push_back(o);
                if (o_mem_we) begin
                    mem[o_mem_addr] = merge(mem_rd(o_mem_addr), o_mem_wdata, o_mem_be);
                end else begin
                    pend      = 1;
                    pend_cnt  = (rd_lat >= 0) ? rd_lat : int'($urandom_range(0, 2));
                    pend_data = mem_rd(o_mem_addr);
                end
            end
            if (o_bvalid || o_rvalid) check_eq("req_idle", o_mem_req, 0);
        end
    end

    task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, output bit ok);
        i_awid = id; i_awaddr = addr; i_awlen = len; i_awburst = burst; i_awvalid = 1;
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk); #2;
            if (o_awready) ok = 1;
            @(posedge clk); #1;
        end
        i_awvalid = 0;
        if (!ok) check_eq("aw_timeout", 0, 1);
    endtask

    task automatic ar_send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, output bit ok);
        i_arid = id; i_araddr = addr; i_arlen = len; i_arburst = burst; i_arvalid = 1;
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk); #2;
            if (o_arready) ok = 1;
            @(posedge clk); #1;
        end
        i_arvalid = 0;
        if (!ok) check_eq("ar_timeout", 0, 1);
    endtask

    // Data beats, response and memory-operation comparison for one write burst.
    task automatic w_phase(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int wlast_pos, input bit directed);
        op_t           e[$];
        op_t           x;
        bit            ok;
        int            nb;
        logic [WA-1:0] wa;
        ops.delete();
        nb = (wlast_pos < int'(len)) ? wlast_pos + 1 : int'(len) + 1;
        wa = addr[31:3];
        for (int b = 0; b < nb; b++) begin
            i_wdata = directed ? 64'h1122334455667788 : {$urandom, $urandom};
            i_wstrb = directed ? 8'hFF : 8'($urandom);
            i_wlast = (b == wlast_pos);
            ok = 0;
            for (int c = 0; c < 400 && !ok; c++) begin
                i_wvalid = directed || ($urandom_range(0, 3) != 0);
                @(negedge clk); #2;
                if (i_wvalid && o_wready) ok = 1;
                @(posedge clk); #1;
            end
            i_wvalid = 0;
            if (!ok) begin
                check_eq("w_timeout", 0, 1);
                return;
            end
            x.we = 1; x.addr = wa; x.data = i_wdata; x.be = i_wstrb;
            e.push_back(x);
            ref_mem[wa] = merge(ref_rd(wa), i_wdata, i_wstrb);
            if (burst != 2'b00) wa++;
        end
        i_wlast = 0;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk); #2;
            if (o_bvalid) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            check_eq("b_timeout", 0, 1);
            return;
        end
        check_eq("bid", o_bid, id);
        check_eq("bresp", o_bresp, (wlast_pos != int'(len)) ? 2'b10 : 2'b00);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1; @(negedge clk); #2;
            check_eq("bvalid_hold", o_bvalid, 1);
        end
        i_bready = 1;
        @(posedge clk); #1;
        i_bready = 0;
        check_eq("wr_beats", ops.size(), e.size());
        for (int i = 0; i < e.size() && i < ops.size(); i++) begin
            check_eq("wr_we", ops[i].we, 1);
            check_eq("wr_addr", ops[i].addr, e[i].addr);
            check_eq("wr_data", ops[i].data, e[i].data);
            check_eq("wr_be", ops[i].be, e[i].be);
        end
    endtask

    task automatic r_phase(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit stall0);
        logic [WA-1:0] wa;
        logic [WA-1:0] ea[$];
        logic [63:0]   expd;
        bit            ok;
        int            n;
        ops.delete();
        wa = addr[31:3];
        for (int b = 0; b <= int'(len); b++) begin
            ok = 0;
            for (int c = 0; c < 400 && !ok; c++) begin
                @(negedge clk); #2;
                if (o_rvalid) ok = 1;
                else begin @(posedge clk); #1; end
            end
            if (!ok) begin
                check_eq("r_timeout", 0, 1);
                return;
            end
            expd = ref_rd(wa);
            check_eq("rdata", o_rdata, expd);
            check_eq("rid", o_rid, id);
            check_eq("rlast", o_rlast, b == int'(len));
            check_eq("rresp", o_rresp, 2'b00);
            n = (stall0 && b == 0) ? 5 : int'($urandom_range(0, 1));
            for (int s = 0; s < n; s++) begin
                @(posedge clk); #1; @(negedge clk); #2;
                check_eq("rvalid_hold", o_rvalid, 1);
                check_eq("rdata_hold", o_rdata, expd);
                check_eq("rid_hold", o_rid, id);
            end
            i_rready = 1;
            @(posedge clk); #1;
            i_rready = 0;
            ea.push_back(wa);
            if (burst != 2'b00) wa++;
        end
        check_eq("rd_beats", ops.size(), ea.size());
        for (int i = 0; i < ea.size() && i < ops.size(); i++) begin
            check_eq("rd_we", ops[i].we, 0);
            check_eq("rd_addr", ops[i].addr, ea[i]);
        end
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int wlast_pos, input bit directed);
        bit ok;
        aw_send(id, addr, len, burst, ok);
        if (ok) w_phase(id, addr, len, burst, wlast_pos, directed);
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit stall0);
        bit ok;
        ar_send(id, addr, len, burst, ok);
        if (ok) r_phase(id, addr, len, burst, stall0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit            ok;
        logic [31:0]   addr;
        logic [7:0]    len;
        logic [1:0]    burst;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_awready", o_awready, 0);
        check_eq("rst_arready", o_arready, 0);
        check_eq("rst_bvalid", o_bvalid, 0);
        check_eq("rst_rvalid", o_rvalid, 0);
        check_eq("rst_req", o_mem_req, 0);
        check_eq("rst_we", o_mem_we, 0);
        check_eq("rst_bid", o_bid, 0);
        check_eq("rst_rid", o_rid, 0);
        check_eq("rst_bresp", o_bresp, 0);
        check_eq("rst_rdata", o_rdata, 0);
        check_eq("rst_addr", o_mem_addr, 0);
        rst_n = 1;
        rd_first = 1;
        @(posedge clk); #1;

        // Simultaneous AW/AR, twice: arbitration alternates starting with read.
        for (int k = 0; k < 2; k++) begin
            i_arid = 6'd3; i_araddr = 32'h40; i_arlen = 0; i_arburst = 2'b01; i_arvalid = 1;
            i_awid = 6'd5; i_awaddr = 32'h80; i_awlen = 0; i_awburst = 2'b01; i_awvalid = 1;
            @(negedge clk); #2;
            check_eq("coll_arready", o_arready, rd_first);
            check_eq("coll_awready", o_awready, !rd_first);
            @(posedge clk); #1;
            if (rd_first) begin
                i_arvalid = 0;
                r_phase(6'd3, 32'h40, 8'd0, 2'b01, 0);
                aw_send(6'd5, 32'h80, 8'd0, 2'b01, ok);
                if (ok) w_phase(6'd5, 32'h80, 8'd0, 2'b01, 0, 0);
            end else begin
                i_awvalid = 0;
                w_phase(6'd5, 32'h80, 8'd0, 2'b01, 0, 0);
                ar_send(6'd3, 32'h40, 8'd0, 2'b01, ok);
                if (ok) r_phase(6'd3, 32'h40, 8'd0, 2'b01, 0);
            end
            rd_first = !rd_first;
        end

        // Directed scenarios.
        do_write(6'd5, 32'h100, 8'd0, 2'b01, 0, 1);
        rd_lat = 1;
        do_read(6'd3, 32'h1000, 8'd3, 2'b01, 0);
        rd_lat = -1;
        do_read(6'd7, 32'h100, 8'd1, 2'b01, 1);
        do_write(6'd1, 32'h200, 8'd3, 2'b01, 1, 0);
        do_write(6'd2, 32'h300, 8'd2, 2'b00, 2, 0);
        do_write(6'd4, 32'h308, 8'd2, 2'b01, 5, 0);
        do_read(6'd2, 32'h300, 8'd2, 2'b00, 0);
        do_write(6'd7, 32'h0, 8'd255, 2'b01, 255, 0);
        do_read(6'd7, 32'h0, 8'd255, 2'b01, 0);
        do_write(6'd6, 32'hFFFF_FFF0, 8'd3, 2'b10, 3, 0);
        do_read(6'd6, 32'hFFFF_FFF0, 8'd3, 2'b01, 0);

        // Reset while a read waits for memory data.
        resp_hold = 1;
        ops.delete();
        ar_send(6'd9, 32'h3000, 8'd3, 2'b01, ok);
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk); #2;
            if (ops.size() > 0) ok = 1;
        end
        check_eq("rdwait_gnt", ok, 1);
        @(posedge clk); #1;
        check_eq("rdwait_req", o_mem_req, 0);
        check_eq("rdwait_rvalid", o_rvalid, 0);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check_eq("arst_rvalid", o_rvalid, 0);
        check_eq("arst_req", o_mem_req, 0);
        check_eq("arst_addr", o_mem_addr, 0);
        check_eq("arst_rid", o_rid, 0);
        resp_hold = 0;
        @(posedge clk); #1;
        rst_n = 1;
        rd_first = 1;
        @(posedge clk); #1;
        do_write(6'd12, 32'h3000, 8'd1, 2'b01, 1, 0);
        do_read(6'd13, 32'h3000, 8'd1, 2'b01, 0);

        // Randomised traffic.
        for (int t = 0; t < 60; t++) begin
            gnt_pct = int'($urandom_range(30, 100));
            addr  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFE0 + $urandom_range(0, 31)
                                                : 32'($urandom_range(0, 511));
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                do_write(6'($urandom), addr, len, burst,
                         ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : int'(len), 0);
            end else begin
                do_read(6'($urandom), addr, len, burst, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
